ram_rd_pipe: RTL and testbench
==============================

RAM_RD_PIPE -- requirements
Module: ram_rd_pipe

Interface
REQ-001 Parameter pW, default 36, data word width in bits.
REQ-002 Parameter pA, default 10, address width in bits; RAM depth SHALL be 2**pA words.
REQ-003 iclk  input  1  single clock; all logic SHALL be rising-edge on iclk.
REQ-004 irst_n  input  1  reset, asynchronous, active-low.
REQ-005 iclk_ena  input  1  clock enable; all state updates SHALL be qualified by it.
REQ-006 iwrena  input  1  write strobe from the upstream address generator.
REQ-007 iwr_adr  input  pA  write address.
REQ-008 idat  input  pW  write data.
REQ-009 irdena  input  1  read strobe from the upstream address generator.
REQ-010 ird_adr  input  pA  read address.
REQ-011 iclr  input  1  synchronous clear of the collision counter.
REQ-012 oval  output  1  read data valid.
REQ-013 odat  output  pW  read data.
REQ-014 ord_adr  output  pA  address echo aligned with odat.
REQ-015 ocoll_cnt  output  16  saturating count of same-address read/write cycles.

Function
REQ-016 Enabled cycle SHALL mean iclk_ena=1; with iclk_ena=0, writes, reads, pipeline, counter and outputs SHALL hold.
REQ-017 Enabled cycle with iwrena=1 SHALL write idat to RAM[iwr_adr].
REQ-018 Enabled cycle N with irdena=1 SHALL produce oval=1, odat=RAM[ird_adr], ord_adr=ird_adr after 2 enabled cycles (latency 2: RAM register, output register).
REQ-019 Pipeline SHALL accept one read per enabled cycle, back-to-back, with no bubbles; oval SHALL be 0 in cycles with no matching read.
REQ-020 odat and ord_adr SHALL hold their last value while oval=0.
REQ-021 Collision: an enabled cycle with iwrena=1, irdena=1, iwr_adr==ird_adr; the read data SHALL follow REQ-030/REQ-031.
REQ-022 Write in enabled cycle N+1 to a read address sampled in cycle N SHALL NOT affect that read's data.
REQ-023 Each collision SHALL increment ocoll_cnt by 1, saturating at 16'hFFFF.
REQ-024 iclr=1 in an enabled cycle SHALL set ocoll_cnt to 0; iclr wins over a simultaneous collision.
REQ-025 Address wrap: addresses are used modulo 2**pA; no range checking.

Reset
REQ-026 irst_n=0 SHALL asynchronously force oval=0, odat=0, ord_adr=0, ocoll_cnt=0, and clear internal valid stages.
REQ-027 Reads in flight at reset assertion SHALL be discarded; no oval pulse after deassertion for them.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 First read SHALL be accepted in the first enabled cycle after irst_n deassertion.

Configuration
REQ-030 With RAM_RD_BYPASS_EN defined, a collision read SHALL return the idat written that cycle (write-first forwarding).
REQ-031 Without RAM_RD_BYPASS_EN, a collision read SHALL return the RAM contents before the write (read-first); ocoll_cnt SHALL count in both builds.

Structure
REQ-032 Shared package ram_rd_pipe_pkg SHALL hold localparam RD_LAT=2, COLL_CNT_W=16, and typedef coll_cnt_t.
REQ-033 Sub-module dp_ram SHALL implement the simple dual-port RAM (one write, one registered read port, read-first, no reset) for vendor inference.
REQ-034 Forwarding mux, valid/address pipeline and counter SHALL live in ram_rd_pipe.

Verification
REQ-035 Write 0x123456789 to adr 5; read adr 5 two cycles later -> oval=1, odat=0x123456789, ord_adr=5 exactly 2 cycles after the read.
REQ-036 RAM[7]=0xA, same cycle write 0xB to adr 7 and read adr 7 -> odat=0xB with macro, 0xA without; ocoll_cnt=1.
REQ-037 Reads adr 0..15 back-to-back with iclk_ena toggling 1/0 -> 16 oval pulses in order, each 2 enabled cycles after its read.
REQ-038 Assert irst_n=0 one cycle after three reads are issued -> outputs 0 immediately, no oval after release.
REQ-039 Force 65537 collisions, then iclr=1 with a collision -> ocoll_cnt=0xFFFF, then 0.
REQ-040 Read adr 2**pA-1 then write/read adr 0 -> correct data, no aliasing.

Source files
------------

// File: rtl/ram_rd_pipe_pkg.sv
// ram_rd_pipe_pkg: shared constants and types for the registered RAM read pipeline.
package ram_rd_pipe_pkg;

    localparam int RD_LAT     = 2;
    localparam int COLL_CNT_W = 16;

    typedef logic [COLL_CNT_W-1:0] coll_cnt_t;

    // Saturating increment for the collision counter.
    function automatic coll_cnt_t coll_sat_inc(input coll_cnt_t c);
        return (c == '1) ? c : c + coll_cnt_t'(1);
    endfunction

endpackage

// File: rtl/ram_rd_pipe_dp_ram.sv
// dp_ram: simple dual-port RAM, one write port and one registered read port.
// Read-first on same-address access; no reset on storage or read register,
// so vendor tools can map it onto block RAM.
module dp_ram
    import ram_rd_pipe_pkg::*;
#(
    parameter int pW = 36,
    parameter int pA = 10
) (
    input  logic          iclk,
    input  logic          iclk_ena,
    input  logic          iwrena,
    input  logic [pA-1:0] iwr_adr,
    input  logic [pW-1:0] idat,
    input  logic          irdena,
    input  logic [pA-1:0] ird_adr,
    output logic [pW-1:0] odat
);

    logic [pW-1:0] mem [0:(1<<pA)-1];

    // Write and registered read; nonblocking read sees pre-write contents.
    always_ff @(posedge iclk) begin
        if (iclk_ena) begin
            if (iwrena) mem[iwr_adr] <= idat;
            if (irdena) odat <= mem[ird_adr];
        end
    end

endmodule

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: two-stage RAM read pipeline (RAM register + output register)
// with address echo and a saturating same-address read/write counter.
// Optional macro RAM_RD_BYPASS_EN: collision reads return the data written in
// that cycle (write-first); otherwise they return the old RAM contents.
module ram_rd_pipe
    import ram_rd_pipe_pkg::*;
#(
    parameter int pW = 36,
    parameter int pA = 10
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          iclk_ena,
    input  logic          iwrena,
    input  logic [pA-1:0] iwr_adr,
    input  logic [pW-1:0] idat,
    input  logic          irdena,
    input  logic [pA-1:0] ird_adr,
    input  logic          iclr,
    output logic          oval,
    output logic [pW-1:0] odat,
    output logic [pA-1:0] ord_adr,
    output logic [15:0]   ocoll_cnt
);

    logic            coll;
    logic [pW-1:0]   ram_q;
    logic [pW-1:0]   rd_dat_s1;
    logic [pA-1:0]   adr_s1;
    logic [RD_LAT:1] vld_pipe;
    coll_cnt_t       coll_cnt;

    assign coll = iwrena & irdena & (iwr_adr == ird_adr);

    dp_ram #(.pW(pW), .pA(pA)) u_ram (
        .iclk     (iclk),
        .iclk_ena (iclk_ena),
        .iwrena   (iwrena),
        .iwr_adr  (iwr_adr),
        .idat     (idat),
        .irdena   (irdena),
        .ird_adr  (ird_adr),
        .odat     (ram_q)
    );

`ifdef RAM_RD_BYPASS_EN
    logic          byp_s1;
    logic [pW-1:0] byp_dat_s1;

    // Remember that the stage-1 read collided so the written word replaces RAM data.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)       byp_s1 <= 1'b0;
        else if (iclk_ena) byp_s1 <= coll;
    end

    // Capture the colliding write data; only consumed when byp_s1 is set.
    always_ff @(posedge iclk) begin
        if (iclk_ena && coll) byp_dat_s1 <= idat;
    end

    assign rd_dat_s1 = byp_s1 ? byp_dat_s1 : ram_q;
`else
    assign rd_dat_s1 = ram_q;
`endif

    // Valid shift register and stage-1 address, aligned with the RAM register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            vld_pipe <= '0;
            adr_s1   <= '0;
        end else if (iclk_ena) begin
            vld_pipe <= {vld_pipe[RD_LAT-1:1], irdena};
            if (irdena) adr_s1 <= ird_adr;
        end
    end

    // Output register: data and address only move on a valid read, else hold.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            odat    <= '0;
            ord_adr <= '0;
        end else if (iclk_ena && vld_pipe[RD_LAT-1]) begin
            odat    <= rd_dat_s1;
            ord_adr <= adr_s1;
        end
    end

    assign oval = vld_pipe[RD_LAT];

    // Collision counter; clear has priority over a same-cycle collision.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)       coll_cnt <= '0;
        else if (iclk_ena) begin
            if (iclr)      coll_cnt <= '0;
            else if (coll) coll_cnt <= coll_sat_inc(coll_cnt);
        end
    end

    assign ocoll_cnt = coll_cnt;

endmodule

// File: tb/tb_ram_rd_pipe.sv
// tb_ram_rd_pipe: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ram_rd_pipe;

    localparam int W = 36;
    localparam int A = 10;
    localparam int D = 1 << A;

`ifdef RAM_RD_BYPASS_EN
    localparam logic [W-1:0] COLL_EXP = 36'hB;
`else
    localparam logic [W-1:0] COLL_EXP = 36'hA;
`endif

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          iclk_ena = 1'b0;
    logic          iwrena = 1'b0;
    logic [A-1:0]  iwr_adr = '0;
    logic [W-1:0]  idat = '0;
    logic          irdena = 1'b0;
    logic [A-1:0]  ird_adr = '0;
    logic          iclr = 1'b0;
    logic          oval;
    logic [W-1:0]  odat;
    logic [A-1:0]  ord_adr;
    logic [15:0]   ocoll_cnt;

    int n_chk = 0;
    int n_err = 0;

    ram_rd_pipe #(.pW(W), .pA(A)) dut (
        .iclk(iclk), .irst_n(irst_n), .iclk_ena(iclk_ena),
        .iwrena(iwrena), .iwr_adr(iwr_adr), .idat(idat),
        .irdena(irdena), .ird_adr(ird_adr), .iclr(iclr),
        .oval(oval), .odat(odat), .ord_adr(ord_adr), .ocoll_cnt(ocoll_cnt)
    );

    always #5 iclk = ~iclk;

    // Reference model: RAM array plus a one-entry delay queue of read results.
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [A-1:0] a;
    } rd_t;

    logic [W-1:0] mem [D];
    rd_t          pq [$];
    logic         m_oval;
    logic [W-1:0] m_dat;
    logic [A-1:0] m_adr;
    logic [15:0]  m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rd_t b;
        b.v = 1'b0; b.d = '0; b.a = '0;
        pq.delete();
        pq.push_back(b);
        m_oval = 1'b0; m_dat = '0; m_adr = '0; m_cnt = '0;
    endtask

    task automatic check_model();
        chk("oval", 64'(oval), 64'(m_oval));
        chk("odat", 64'(odat), 64'(m_dat));
        chk("ord_adr", 64'(ord_adr), 64'(m_adr));
        chk("ocoll_cnt", 64'(ocoll_cnt), 64'(m_cnt));
    endtask

    // One cycle: drive at negedge, advance model at posedge, check at next negedge.
    task automatic step(input logic ena, input logic wre, input logic [A-1:0] wa,
                        input logic [W-1:0] d, input logic rde, input logic [A-1:0] ra,
                        input logic clr, input bit do_chk);
        rd_t nr, fr;
        logic c;
        iclk_ena = ena; iwrena = wre; iwr_adr = wa; idat = d;
        irdena = rde; ird_adr = ra; iclr = clr;
        @(posedge iclk);
        if (ena) begin
            c = wre && rde && (wa == ra);
            nr.v = rde; nr.a = ra; nr.d = mem[ra];
`ifdef RAM_RD_BYPASS_EN
            if (c) nr.d = d;
`endif
            fr = pq.pop_front();
            pq.push_back(nr);
            m_oval = fr.v;
            if (fr.v) begin m_dat = fr.d; m_adr = fr.a; end
            if (wre) mem[wa] = d;
            if (clr) m_cnt = '0;
            else if (c && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        @(negedge iclk);
        if (do_chk) check_model();
    endtask

    typedef struct {
        logic         ena, wre;
        logic [A-1:0] wa;
        logic [W-1:0] d;
        logic         rde;
        logic [A-1:0] ra;
        logic         clr;
        logic         e_val;
        logic [W-1:0] e_dat;
        logic [A-1:0] e_adr;
        logic [15:0]  e_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [63:0] r;
        int pulses;
        logic [A-1:0] nxt;

        tbl[0]  = '{1, 1, 5, 36'h123456789, 0, 0, 0,  0, 36'h0, 0, 0};
        tbl[1]  = '{1, 1, 7, 36'hA,         0, 0, 0,  0, 36'h0, 0, 0};
        tbl[2]  = '{1, 0, 0, 36'h0,         1, 5, 0,  0, 36'h0, 0, 0};
        tbl[3]  = '{1, 1, 7, 36'hB,         1, 7, 0,  1, 36'h123456789, 5, 1};
        tbl[4]  = '{1, 0, 0, 36'h0,         0, 0, 0,  1, COLL_EXP, 7, 1};
        tbl[5]  = '{1, 0, 0, 36'h0,         0, 0, 0,  0, COLL_EXP, 7, 1};
        tbl[6]  = '{0, 0, 0, 36'h0,         1, 7, 0,  0, COLL_EXP, 7, 1};
        tbl[7]  = '{1, 0, 0, 36'h0,         1, 7, 0,  0, COLL_EXP, 7, 1};
        tbl[8]  = '{1, 0, 0, 36'h0,         0, 0, 0,  1, 36'hB, 7, 1};
        tbl[9]  = '{1, 0, 0, 36'h0,         0, 0, 1,  0, 36'hB, 7, 0};
        tbl[10] = '{1, 0, 0, 36'h0,         1, 5, 0,  0, 36'hB, 7, 0};
        tbl[11] = '{1, 1, 5, 36'h55,        0, 0, 0,  1, 36'h123456789, 5, 0};
        tbl[12] = '{1, 0, 0, 36'h0,         1, 5, 0,  0, 36'h123456789, 5, 0};
        tbl[13] = '{1, 0, 0, 36'h0,         0, 0, 0,  1, 36'h55, 5, 0};

        model_reset();
        for (int i = 0; i < D; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge iclk);
        chk("rst_oval", 64'(oval), 64'd0);
        chk("rst_odat", 64'(odat), 64'd0);
        chk("rst_adr", 64'(ord_adr), 64'd0);
        chk("rst_cnt", 64'(ocoll_cnt), 64'd0);
        irst_n = 1'b1;

        // Fill every RAM word so later reads have known contents
        for (int i = 0; i < D; i++) begin
            r = {32'($urandom), 32'($urandom)};
            step(1, 1, A'(i), r[W-1:0], 0, 0, 0, 1);
        end

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].ena, tbl[i].wre, tbl[i].wa, tbl[i].d, tbl[i].rde, tbl[i].ra, tbl[i].clr, 1);
            chk($sformatf("vec%0d_oval", i), 64'(oval), 64'(tbl[i].e_val));
            chk($sformatf("vec%0d_odat", i), 64'(odat), 64'(tbl[i].e_dat));
            chk($sformatf("vec%0d_adr", i), 64'(ord_adr), 64'(tbl[i].e_adr));
            chk($sformatf("vec%0d_cnt", i), 64'(ocoll_cnt), 64'(tbl[i].e_cnt));
        end

        // Back-to-back reads 0..15 with clock enable toggling
        pulses = 0; nxt = '0;
        for (int i = 0; i < 36; i++) begin
            logic e;
            e = (i % 2 == 0);
            step(e, 0, 0, '0, (i < 32), A'(i / 2), 0, 1);
            if (e && oval) begin
                chk("seq_adr", 64'(ord_adr), 64'(nxt));
                chk("seq_dat", 64'(odat), 64'(mem[nxt]));
                nxt++;
                pulses++;
            end
        end
        chk("seq_pulses", 64'(pulses), 64'd16);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [A-1:0] wa, ra;
            r = {32'($urandom), 32'($urandom)};
            wa = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? wa : A'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, 1'($urandom), wa, r[W-1:0], 1'($urandom), ra,
                 $urandom_range(0, 49) == 0, 1);
        end

        // Address wrap: top and bottom words stay distinct
        step(1, 1, A'(D - 1), 36'hF00DF00D1, 0, 0, 0, 1);
        step(1, 1, 0, 36'h0BEEF0002, 0, 0, 0, 1);
        step(1, 0, 0, '0, 1, A'(D - 1), 0, 1);
        step(1, 0, 0, '0, 1, 0, 0, 1);
        chk("wrap_top_dat", 64'(odat), 64'h0_F00DF00D1);
        chk("wrap_top_adr", 64'(ord_adr), 64'(D - 1));
        step(1, 0, 0, '0, 0, 0, 0, 1);
        chk("wrap_bot_dat", 64'(odat), 64'h0_0BEEF0002);
        chk("wrap_bot_adr", 64'(ord_adr), 64'd0);

        // Reset with three reads in flight
        step(1, 0, 0, '0, 1, 1, 0, 1);
        step(1, 0, 0, '0, 1, 2, 0, 1);
        step(1, 0, 0, '0, 1, 3, 0, 1);
        chk("pre_rst_oval", 64'(oval), 64'd1);
        irst_n = 1'b0;
        #1;
        chk("arst_oval", 64'(oval), 64'd0);
        chk("arst_odat", 64'(odat), 64'd0);
        chk("arst_adr", 64'(ord_adr), 64'd0);
        chk("arst_cnt", 64'(ocoll_cnt), 64'd0);
        model_reset();
        iclk_ena = 1'b1; irdena = 1'b0; iwrena = 1'b0;
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, '0, 0, 0, 0, 1);
            if (oval) pulses++;
        end
        chk("post_rst_pulses", 64'(pulses), 64'd0);
        // First read after release is accepted
        step(1, 0, 0, '0, 1, 9, 0, 1);
        step(1, 0, 0, '0, 0, 0, 0, 1);
        chk("first_rd_oval", 64'(oval), 64'd1);
        chk("first_rd_adr", 64'(ord_adr), 64'd9);

        // Counter saturation, then clear beats a simultaneous collision
        for (int i = 0; i < 65537; i++) step(1, 1, 3, W'(i), 1, 3, 0, 0);
        check_model();
        chk("sat_cnt", 64'(ocoll_cnt), 64'hFFFF);
        step(1, 1, 3, '0, 1, 3, 1, 1);
        chk("clr_cnt", 64'(ocoll_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
